el2_dec_ib_buf: RTL and testbench



---
 rtl/el2_dec_ib_buf_pkg.sv | 54 +++++
 rtl/el2_dec_ib_buf_if.sv | 29 ++
 rtl/el2_dec_ib_buf_ctl.sv | 60 ++++++
 rtl/el2_dec_ib_buf.sv | 64 ++++++
 tb/tb_el2_dec_ib_buf.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/el2_dec_ib_buf_pkg.sv
// Shared types for the decode-stage instruction buffer: core configuration
// record, branch-prediction packet and the i0 packet that travels from the
// IFU aligner into decode.
package el2_dec_ib_buf_pkg;

    typedef struct packed {
        int unsigned BTB_ADDR_HI;
        int unsigned BTB_ADDR_LO;
        int unsigned BHT_GHR_SIZE;
        int unsigned BTB_BTAG_SIZE;
        int unsigned BTB_SIZE;
    } el2_param_t;

    localparam el2_param_t PT_DEFAULT = '{
        BTB_ADDR_HI:   9,
        BTB_ADDR_LO:   2,
        BHT_GHR_SIZE:  8,
        BTB_BTAG_SIZE: 5,
        BTB_SIZE:      512
    };

    // Field widths of the predictor metadata carried with each packet.
    localparam int BP_INDEX_W = PT_DEFAULT.BTB_ADDR_HI - PT_DEFAULT.BTB_ADDR_LO + 1;
    localparam int BP_FGHR_W  = PT_DEFAULT.BHT_GHR_SIZE;
    localparam int BP_BTAG_W  = PT_DEFAULT.BTB_BTAG_SIZE;
    localparam int FA_INDEX_W = $clog2(PT_DEFAULT.BTB_SIZE);

    typedef struct packed {
        logic        valid;
        logic [11:0] toffset;
        logic [1:0]  hist;
        logic        br_error;
        logic        br_start_error;
        logic [31:1] prett;
        logic        way;
        logic        ret;
    } el2_br_pkt_t;

    typedef struct packed {
        logic [31:0]           instr;
        logic [31:1]           pc;
        logic                  pc4;
        logic                  icaf;
        logic [1:0]            icaf_type;
        logic                  icaf_second;
        logic                  dbecc;
        el2_br_pkt_t           brp;
        logic [BP_INDEX_W-1:0] bp_index;
        logic [BP_FGHR_W-1:0]  bp_fghr;
        logic [BP_BTAG_W-1:0]  bp_btag;
        logic [FA_INDEX_W-1:0] fa_index;
    } el2_ib_pkt_t;

endpackage

// File: rtl/el2_dec_ib_buf_if.sv
// Aligner-side and decode-side handshake of the instruction buffer.
// master = aligner/decode environment, slave = the buffer itself.
interface el2_dec_ib_buf_if
    import el2_dec_ib_buf_pkg::*;
#(
    parameter int IB_DEPTH = 2
) ();

    logic                      ifu_i0_valid;
    el2_ib_pkt_t               ifu_i0_pkt;
    logic                      ib_ready;
    logic                      dec_i0_consume;
    logic                      exu_flush_final;
    logic                      ib_i0_valid;
    el2_ib_pkt_t               ib_i0_pkt;
    logic                      ib_empty;
    logic [$clog2(IB_DEPTH):0] ib_count;

    modport master (
        output ifu_i0_valid, ifu_i0_pkt, dec_i0_consume, exu_flush_final,
        input  ib_ready, ib_i0_valid, ib_i0_pkt, ib_empty, ib_count
    );

    modport slave (
        input  ifu_i0_valid, ifu_i0_pkt, dec_i0_consume, exu_flush_final,
        output ib_ready, ib_i0_valid, ib_i0_pkt, ib_empty, ib_count
    );

endinterface

// File: rtl/el2_dec_ib_buf_ctl.sv
// Control half of the instruction buffer: read/write pointers, occupancy,
// push/pop qualification and flush. Ready depends only on the registered
// count so decode's consume never feeds back into the aligner's handshake.
module el2_dec_ib_buf_ctl #(
    parameter  int IB_DEPTH = 2,
    localparam int PTR_W    = $clog2(IB_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             ifu_valid,
    input  logic             consume,
    input  logic             flush,
    output logic             ready,
    output logic             head_valid,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr
);

    logic push;
    logic pop;

    assign ready      = (count != CNT_W'(IB_DEPTH));
    assign head_valid = (count != '0);
    assign empty      = (count == '0);

    // A flush swallows any handshake that happens in the same cycle.
    assign push  = ifu_valid & ready & ~flush;
    assign pop   = consume & head_valid & ~flush;
    assign wr_en = push;

    // Pointer and occupancy update; pointers wrap naturally at IB_DEPTH.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/el2_dec_ib_buf.sv
// Instruction buffer between the IFU aligner and decode. Holds up to
// IB_DEPTH i0 packets in a circular array and presents the oldest one as a
// registered head; there is no bypass, so a packet is visible one cycle
// after it is accepted. Payloads pass through untouched.
module el2_dec_ib_buf
    import el2_dec_ib_buf_pkg::*;
#(
    parameter el2_param_t pt       = PT_DEFAULT,
    parameter int         IB_DEPTH = 2
) (
    input logic             clk,
    input logic             rst_l,
    el2_dec_ib_buf_if.slave ib
);

    localparam int PTR_W = $clog2(IB_DEPTH);

    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    el2_ib_pkt_t      entry [IB_DEPTH];

    el2_dec_ib_buf_ctl #(
        .IB_DEPTH (IB_DEPTH)
    ) u_ctl (
        .clk        (clk),
        .rst_l      (rst_l),
        .ifu_valid  (ib.ifu_i0_valid),
        .consume    (ib.dec_i0_consume),
        .flush      (ib.exu_flush_final),
        .ready      (ib.ib_ready),
        .head_valid (ib.ib_i0_valid),
        .empty      (ib.ib_empty),
        .count      (ib.ib_count),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr)
    );

    // Entry storage; flush leaves stale payloads in place, only reset clears them.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < IB_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (wr_en) begin
            entry[wr_ptr] <= ib.ifu_i0_pkt;
        end
    end

    assign ib.ib_i0_pkt = entry[rd_ptr];

    // Decode must never consume from an empty buffer.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_l)
        ib.dec_i0_consume |-> ib.ib_i0_valid);

    // Packet field widths are fixed by the package; the core configuration must agree.
    a_cfg_match: assert property (@(posedge clk) disable iff (!rst_l)
        (int'(pt.BTB_ADDR_HI - pt.BTB_ADDR_LO + 1) == BP_INDEX_W) &&
        (int'(pt.BHT_GHR_SIZE) == BP_FGHR_W) &&
        (int'(pt.BTB_BTAG_SIZE) == BP_BTAG_W) &&
        (int'($clog2(pt.BTB_SIZE)) == FA_INDEX_W));

endmodule

// File: tb/tb_el2_dec_ib_buf.sv
// Bench for the instruction buffer: a FIFO reference model (queue plus
// occupancy) fed by the driver, and an independent monitor that checks
// every packet decode consumes against the head of the expected queue.
module tb_el2_dec_ib_buf;
    import el2_dec_ib_buf_pkg::*;

    localparam int DEPTH = 4;
    localparam int PKT_W = $bits(el2_ib_pkt_t);

    logic clk = 1'b0;
    logic rst_l = 1'b0;

    el2_dec_ib_buf_if #(.IB_DEPTH(DEPTH)) ibif ();

    el2_dec_ib_buf #(.IB_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .ib    (ibif)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_cnt = 0;
    logic        accepted;
    el2_ib_pkt_t exp_q[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic el2_ib_pkt_t rand_pkt();
        logic [PKT_W-1:0] v = '0;
        for (int i = 0; i < (PKT_W + 31) / 32; i++) begin
            v = (v << 32) | PKT_W'($urandom);
        end
        return el2_ib_pkt_t'(v);
    endfunction

    function automatic el2_ib_pkt_t pc_pkt(input logic [31:0] pc, input logic [31:0] instr);
        el2_ib_pkt_t p = rand_pkt();
        p.pc    = pc[31:1];
        p.instr = instr;
        return p;
    endfunction

    // Occupancy-derived outputs and the head payload against the model.
    task automatic check_state(input string tag);
        chk({tag, "_count"}, 160'(ibif.ib_count), 160'(model_cnt));
        chk({tag, "_valid"}, 160'(ibif.ib_i0_valid), 160'(model_cnt != 0));
        chk({tag, "_empty"}, 160'(ibif.ib_empty), 160'(model_cnt == 0));
        chk({tag, "_ready"}, 160'(ibif.ib_ready), 160'(model_cnt != DEPTH));
        if (model_cnt != 0 && exp_q.size() != 0) begin
            chk({tag, "_head"}, 160'(ibif.ib_i0_pkt), 160'(exp_q[0]));
        end
    endtask

    // One clock of stimulus: drive, advance the FIFO model, then check.
    task automatic step(input logic v, input el2_ib_pkt_t p, input logic c,
                        input logic f, input string tag);
        bit push, pop;
        ibif.ifu_i0_valid    = v;
        ibif.ifu_i0_pkt      = p;
        ibif.dec_i0_consume  = c;
        ibif.exu_flush_final = f;
        push = v && (model_cnt < DEPTH) && !f;
        pop  = c && (model_cnt > 0) && !f;
        accepted = push;
        if (f) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            if (push) exp_q.push_back(p);
            model_cnt = model_cnt + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4 * DEPTH && model_cnt != 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, tag);
        end
        chk({tag, "_drained"}, 160'(exp_q.size()), 160'(0));
    endtask

    // Monitor: every packet decode actually takes must be the oldest expected one.
    always @(negedge clk) begin
        if (rst_l && ibif.ib_i0_valid && ibif.dec_i0_consume && !ibif.exu_flush_final) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_order: got pc=%h expected no packet", ibif.ib_i0_pkt.pc);
            end else begin
                chk("pop_order", 160'(ibif.ib_i0_pkt), 160'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        el2_ib_pkt_t a, b, c, pend;
        logic have;
        logic cons;
        int   k;

        ibif.ifu_i0_valid    = 1'b0;
        ibif.ifu_i0_pkt      = '0;
        ibif.dec_i0_consume  = 1'b0;
        ibif.exu_flush_final = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        chk("reset_pkt", 160'(ibif.ib_i0_pkt), 160'(0));
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        check_state("idle");

        // Single pass
        a = pc_pkt(32'h8000_0000, 32'h0000_0013);
        step(1'b1, a, 1'b0, 1'b0, "single_push");
        chk("single_pc", 160'({ibif.ib_i0_pkt.pc, 1'b0}), 160'(32'h8000_0000));
        chk("single_instr", 160'(ibif.ib_i0_pkt.instr), 160'(32'h0000_0013));
        step(1'b0, '0, 1'b1, 1'b0, "single_pop");

        // Fill to full, hold the extra packet, then release it by consuming
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, rand_pkt(), 1'b0, 1'b0, "fill");
        end
        c = rand_pkt();
        step(1'b1, c, 1'b0, 1'b0, "full_hold");
        chk("full_blocked", 160'(accepted), 160'(0));
        step(1'b1, c, 1'b1, 1'b0, "full_pop");
        chk("full_pop_blocked", 160'(accepted), 160'(0));
        step(1'b1, c, 1'b0, 1'b0, "full_accept");
        chk("full_accepted", 160'(accepted), 160'(1));
        drain("full_drain");

        // Simultaneous push and pop at count 1
        a = rand_pkt();
        b = rand_pkt();
        step(1'b1, a, 1'b0, 1'b0, "pp_one");
        step(1'b1, b, 1'b1, 1'b0, "pp_both");
        chk("pp_head_b", 160'(ibif.ib_i0_pkt), 160'(b));
        drain("pp_drain");

        // Ten sequential packets with random stalls, wrapping the pointers
        k = 0;
        have = 1'b0;
        pend = '0;
        for (int i = 0; i < 200 && (k < 10 || model_cnt != 0); i++) begin
            if (!have && k < 10 && $urandom_range(0, 2) != 0) begin
                pend = pc_pkt(32'h100 + 32'(4 * k), $urandom);
                have = 1'b1;
            end
            cons = (model_cnt != 0) && ($urandom_range(0, 2) != 0);
            step(have, pend, cons, 1'b0, "wrap");
            if (accepted) begin
                have = 1'b0;
                k++;
            end
        end
        chk("wrap_all_sent", 160'(k), 160'(10));
        chk("wrap_drained", 160'(exp_q.size()), 160'(0));

        // Flush with two entries plus a concurrent push and consume
        step(1'b1, rand_pkt(), 1'b0, 1'b0, "fl_a");
        step(1'b1, rand_pkt(), 1'b0, 1'b0, "fl_b");
        step(1'b1, rand_pkt(), 1'b1, 1'b1, "flush");
        a = rand_pkt();
        step(1'b1, a, 1'b0, 1'b0, "post_flush");
        chk("post_flush_head", 160'(ibif.ib_i0_pkt), 160'(a));
        drain("post_flush_drain");

        // Asynchronous reset in the middle of a cycle with two entries held
        step(1'b1, rand_pkt(), 1'b0, 1'b0, "ar_a");
        step(1'b1, rand_pkt(), 1'b0, 1'b0, "ar_b");
        ibif.ifu_i0_valid = 1'b0;
        #2;
        rst_l = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check_state("async_rst");
        chk("async_rst_pkt", 160'(ibif.ib_i0_pkt), 160'(0));
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        check_state("after_rst");

        // Long random run with occasional flushes
        have = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                pend = rand_pkt();
                have = 1'b1;
            end
            cons = (model_cnt != 0) && ($urandom_range(0, 2) != 0);
            step(have, pend, cons, ($urandom_range(0, 39) == 0), "rand");
            if (accepted) have = 1'b0;
        end
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
